// File: rtl/button_request_latch.sv
// Turns the debounced button level into a press strobe, sticky request flags and an
// overrun flag for the controller. Optional long-press support: LONG_PRESS_EN.
module button_request_latch #(
    parameter int CNT_W      = 19,
    parameter int LONG_COUNT = 400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clean,
    input  logic       ack,
    output logic       press_pulse,
    output logic       req,
    output logic       long_req,
    output logic       overrun,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DOWN     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t state, state_n;
    logic   clean_q;
    logic   rise;
    logic   set_s;
    logic   ov_set;

`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
    localparam logic [CNT_W-1:0] LONG_HIT  = CNT_W'(LONG_COUNT - 2);

    logic [CNT_W-1:0] count, count_n;
    logic             set_l;
`endif

    assign fsm_state = state;

    always_comb begin
        rise    = clean & ~clean_q;
        state_n = state;
        set_s   = 1'b0;
`ifdef LONG_PRESS_EN
        set_l   = 1'b0;
        count_n = count;
`else
        set_s   = rise;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = DOWN;
`ifdef LONG_PRESS_EN
                    count_n = '0;
`endif
                end
            end
            DOWN: begin
                if (!clean) begin
                    state_n = IDLE;
`ifdef LONG_PRESS_EN
                    // Released before the long threshold: this is a normal press.
                    set_s   = 1'b1;
                    count_n = '0;
`endif
                end
`ifdef LONG_PRESS_EN
                else if (count == LONG_HIT) begin
                    set_l   = 1'b1;
                    state_n = WAIT_REL;
                    count_n = '0;
                end else if (count != LONG_LAST) begin
                    count_n = count + 1'b1;
                end
`endif
            end
            WAIT_REL: begin
                if (!clean) state_n = IDLE;
`ifdef LONG_PRESS_EN
                count_n = '0;
`endif
            end
            default: state_n = IDLE;
        endcase

`ifdef LONG_PRESS_EN
        ov_set = ~ack & ((set_s & req) | (set_l & long_req));
`else
        ov_set = ~ack & set_s & req;
`endif
    end

    // A set in the same cycle as ack wins, so a fresh event is never lost to an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            clean_q     <= clean;
            state       <= clean ? WAIT_REL : IDLE;
            press_pulse <= 1'b0;
            req         <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            clean_q     <= clean;
            state       <= state_n;
            press_pulse <= rise;
            if (set_s)    req <= 1'b1;
            else if (ack) req <= 1'b0;
            if (ov_set)   overrun <= 1'b1;
            else if (ack) overrun <= 1'b0;
        end
    end

`ifdef LONG_PRESS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            long_req <= 1'b0;
            count    <= '0;
        end else begin
            count <= count_n;
            if (set_l)    long_req <= 1'b1;
            else if (ack) long_req <= 1'b0;
        end
    end
`else
    assign long_req = 1'b0;
`endif

endmodule

// File: tb/tb_button_request_latch.sv
// Directed checks of button_request_latch: strobe/request timing, ack priority,
// overrun, reset while held, and long-press timing when LONG_PRESS_EN is defined.
module tb_button_request_latch;

    logic       clk = 1'b0;
    logic       reset;
    logic       clean;
    logic       ack;
    logic       press_pulse;
    logic       req;
    logic       long_req;
    logic       overrun;
    logic [1:0] fsm_state;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DOWN = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    button_request_latch #(
        .CNT_W      (19),
        .LONG_COUNT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clean       (clean),
        .ack         (ack),
        .press_pulse (press_pulse),
        .req         (req),
        .long_req    (long_req),
        .overrun     (overrun),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic p, input logic r,
                             input logic l, input logic o);
        chk({tag, ".press_pulse"}, {1'b0, press_pulse}, {1'b0, p});
        chk({tag, ".req"},         {1'b0, req},         {1'b0, r});
        chk({tag, ".long_req"},    {1'b0, long_req},    {1'b0, l});
        chk({tag, ".overrun"},     {1'b0, overrun},     {1'b0, o});
    endtask

    initial begin
        reset = 1'b1;
        clean = 1'b0;
        ack   = 1'b0;
        step();
        step();
        chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.state", fsm_state, S_IDLE);
        reset = 1'b0;
        step();
        step();

`ifndef LONG_PRESS_EN
        // Basic press: strobe for one cycle, request from the same edge.
        clean = 1'b1;
        step();
        chk_flags("t1.press", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1.state", fsm_state, S_DOWN);
        step();
        chk_flags("t1.after", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        chk_flags("t1.hold", 1'b0, 1'b1, 1'b0, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_flags("t1.ack", 1'b0, 1'b0, 1'b0, 1'b0);
        clean = 1'b0;
        step();
        chk("t1.rel_state", fsm_state, S_IDLE);
        step();
        chk_flags("t1.release", 1'b0, 1'b0, 1'b0, 1'b0);

        // Ack arriving with a new rise: set wins, no overrun.
        clean = 1'b1;
        step();
        chk_flags("t2.first", 1'b1, 1'b1, 1'b0, 1'b0);
        clean = 1'b0;
        step();
        clean = 1'b1;
        ack   = 1'b1;
        step();
        ack = 1'b0;
        chk_flags("t2.ack_rise", 1'b1, 1'b1, 1'b0, 1'b0);
        clean = 1'b0;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_flags("t2.clear", 1'b0, 1'b0, 1'b0, 1'b0);

        // Second press while pending without ack: overrun, one ack clears both.
        clean = 1'b1;
        step();
        clean = 1'b0;
        step();
        clean = 1'b1;
        step();
        chk_flags("t3.second", 1'b1, 1'b1, 1'b0, 1'b1);
        clean = 1'b0;
        step();
        chk_flags("t3.hold", 1'b0, 1'b1, 1'b0, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_flags("t3.ack", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_flags("t3.idle_ack_noop", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Button held through reset never yields an event.
        reset = 1'b1;
        clean = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("t4.state", fsm_state, S_WAIT);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_flags("t4.held", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        clean = 1'b0;
        step();
        chk_flags("t4.release", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4.rel_state", fsm_state, S_IDLE);
        clean = 1'b1;
        step();
`ifdef LONG_PRESS_EN
        chk_flags("t4.later_press", 1'b1, 1'b0, 1'b0, 1'b0);
        clean = 1'b0;
        step();
        chk_flags("t4.later_rel", 1'b0, 1'b1, 1'b0, 1'b0);
`else
        chk_flags("t4.later_press", 1'b1, 1'b1, 1'b0, 1'b0);
        clean = 1'b0;
        step();
`endif
        // Reset mid-request drops everything.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_flags("t4.reset_abort", 1'b0, 1'b0, 1'b0, 1'b0);
        step();

`ifdef LONG_PRESS_EN
        // Short press: request appears on the release edge.
        clean = 1'b1;
        step();
        chk_flags("t5.press", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk_flags("t5.held", 1'b0, 1'b0, 1'b0, 1'b0);
        clean = 1'b0;
        step();
        chk_flags("t5.release", 1'b0, 1'b1, 1'b0, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_flags("t5.ack", 1'b0, 1'b0, 1'b0, 1'b0);

        // Long press: long_req 7 edges after the strobe edge, no req on release.
        clean = 1'b1;
        step();
        chk_flags("t6.press", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 7; i++) begin
            step();
            chk_flags("t6.before", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step();
        chk_flags("t6.long", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6.state", fsm_state, S_WAIT);
        for (int i = 0; i < 4; i++) step();
        clean = 1'b0;
        step();
        chk_flags("t6.release", 1'b0, 1'b0, 1'b1, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_flags("t6.ack", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
